// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame geometry,
// command/response bytes and frame-bit helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam int FRAME_BITS  = 11;
  // Start bit goes out in REQ; the device clocks the remaining bits except ACK.
  localparam int SHIFT_FALLS = FRAME_BITS - 1;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit to present after fall idx+1: data LSB first, parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic par,
                                     input logic [3:0] idx);
    logic r;
    r = 1'b1;
    if (idx < 4'd8)       r = b[idx[2:0]];
    else if (idx == 4'd8) r = par;
    return r;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a
// falling-edge detector on the synced clock.
module ps2_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o
);

  logic clk_meta_q, clk_s_q, clk_prev_q;
  logic data_meta_q, data_s_q;

  // Idle bus level is high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_s_q     <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_s_q    <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_s_q     <= clk_meta_q;
      clk_prev_q  <= clk_s_q;
      data_meta_q <= ps2_data_i;
      data_s_q    <= data_meta_q;
    end
  end

  assign clk_s_o  = clk_s_q;
  assign data_s_o = data_s_q;
  assign fall_o   = clk_prev_q & ~clk_s_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift the
// frame on device clock falls, sample ACK, then wait for the bus to idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_e state_q;
  logic [7:0]    byte_q;
  logic          par_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          nack_q;
  logic          clk_oe_q, data_oe_q, busy_q, ready_q;
  logic          done_q, ack_err_q, timeout_q;

  logic clk_s, data_s, fall;
  logic in_frame, to_hit;

  ps2_sync u_sync (
    .clk_i      (CLK),
    .rst_i      (reset),
    .ps2_clk_i  (PS2_CLK),
    .ps2_data_i (PS2_DATA),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  assign in_frame = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
  // A fall in the terminal cycle restarts the count instead of aborting.
  assign to_hit   = in_frame && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      if (to_hit) begin
        state_q   <= IDLE;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        ready_q   <= 1'b1;
        timeout_q <= 1'b1;
        to_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            ready_q <= 1'b1;
            if (tx_valid) begin
              byte_q    <= tx_data;
              par_q     <= odd_parity(tx_data);
              inh_cnt_q <= '0;
              nack_q    <= 1'b0;
              clk_oe_q  <= 1'b1;
              data_oe_q <= 1'b0;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
              state_q   <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
              data_oe_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= REQ;
            end else begin
              inh_cnt_q <= inh_cnt_q + IW'(1);
            end
          end
          REQ: begin
            clk_oe_q <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= SHIFT;
          end
          SHIFT: begin
            if (fall) begin
              to_cnt_q  <= '0;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              data_oe_q <= ~frame_bit(byte_q, par_q, bit_cnt_q);
              if (bit_cnt_q == 4'(SHIFT_FALLS - 1)) state_q <= ACK;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          ACK: begin
            if (fall) begin
              to_cnt_q <= '0;
              nack_q   <= data_s;
              state_q  <= WAIT_IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done_q    <= 1'b1;
              ack_err_q <= nack_q;
              busy_q    <= 1'b0;
              ready_q   <= 1'b1;
              to_cnt_q  <= '0;
              state_q   <= IDLE;
            end else if (fall) begin
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          default: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 5000;
  localparam int TO  = 2000;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       PS2_CLK, PS2_DATA;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;

  int checks = 0, errors = 0;
  int done_cnt = 0, nack_cnt = 0, to_cnt = 0, orphan = 0;

  // Wired-AND bus: host pulls low via oe, device pulls low via its drive.
  assign PS2_CLK  = dev_clk & ~ps2_clk_oe;
  assign PS2_DATA = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (done)             done_cnt++;
    if (ack_err)          nack_cnt++;
    if (timeout)          to_cnt++;
    if (ack_err && !done) orphan++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Request a byte, then measure inhibit and request-to-send lengths.
  task automatic start(input logic [7:0] b, output int inh, output int req);
    @(negedge CLK);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < INH + 100) begin
      inh++;
      @(negedge CLK);
    end
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < 10) begin
      req++;
      @(negedge CLK);
    end
  endtask

  // Device clocks nfalls pulses, samples bits before each rising edge and
  // drives the ACK bit ahead of fall 11. Optionally pokes tx_valid mid-frame.
  task automatic pulses(input int nfalls, input bit ack, input bit inject,
                        output logic [9:0] frame);
    frame = '0;
    for (int k = 1; k <= nfalls; k++) begin
      cyc(5);
      if (k == 11) dev_data = ~ack;
      cyc(5);
      dev_clk = 1'b0;
      cyc(10);
      if (k <= 10) frame[k-1] = PS2_DATA;
      if (inject && k == 3) begin
        chk("inj_ready_low", tx_ready, 1'b0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
      end
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int inh, req, n, d0, a0, t0;
    logic [9:0] fr;

    cyc(3);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {done, ack_err, timeout}, 3'b000);
    reset = 1'b0;
    cyc(1);
    chk("ready_after_rst", tx_ready, 1'b1);

    // CMD_SET_LEDS with ACK
    d0 = done_cnt; a0 = nack_cnt;
    start(CMD_SET_LEDS, inh, req);
    chk("ed_inhibit_len", inh, INH);
    chk("ed_req_len", req, 1);
    chk("ed_shift_clk_oe", ps2_clk_oe, 1'b0);
    chk("ed_start_bit", ps2_data_oe, 1'b1);
    chk("ed_busy", busy, 1'b1);
    pulses(11, 1'b1, 1'b0, fr);
    wait_done(n);
    chk("ed_done_seen", n < 100, 1'b1);
    chk("ed_ack_err", ack_err, 1'b0);
    chk("ed_frame", fr, 10'h3ED);
    cyc(1);
    chk("ed_done_cnt", done_cnt - d0, 1);
    chk("ed_nack_cnt", nack_cnt - a0, 0);
    chk("ed_ready", tx_ready, 1'b1);
    chk("ed_done_width", done, 1'b0);

    // Parity corner cases
    start(8'h00, inh, req);
    pulses(11, 1'b1, 1'b0, fr);
    wait_done(n);
    chk("b00_frame", fr, 10'h300);
    chk("b00_parity", fr[8], 1'b1);
    cyc(5);
    start(8'h01, inh, req);
    pulses(11, 1'b1, 1'b0, fr);
    wait_done(n);
    chk("b01_frame", fr, 10'h201);
    chk("b01_parity", fr[8], 1'b0);
    cyc(5);

    // No ACK from device
    d0 = done_cnt; a0 = nack_cnt;
    start(CMD_SET_LEDS, inh, req);
    pulses(11, 1'b0, 1'b0, fr);
    wait_done(n);
    chk("nack_done_seen", n < 100, 1'b1);
    chk("nack_ack_err", ack_err, 1'b1);
    cyc(1);
    chk("nack_done_cnt", done_cnt - d0, 1);
    chk("nack_err_cnt", nack_cnt - a0, 1);
    chk("nack_orphan", orphan, 0);
    chk("nack_ready", tx_ready, 1'b1);

    // Device silent after request: timeout
    d0 = done_cnt; t0 = to_cnt;
    start(CMD_ECHO, inh, req);
    n = 0;
    while (!timeout && n < TO + 100) begin
      @(negedge CLK);
      n++;
    end
    chk("to_latency", n, TO + 1);
    chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("to_busy", busy, 1'b0);
    cyc(1);
    chk("to_width", timeout, 1'b0);
    chk("to_cnt", to_cnt - t0, 1);
    chk("to_no_done", done_cnt - d0, 0);

    // Reset after fall 4 (bit 3 of 0x00 drives the line low)
    d0 = done_cnt; a0 = nack_cnt; t0 = to_cnt;
    start(8'h00, inh, req);
    pulses(3, 1'b1, 1'b0, fr);
    cyc(10);
    dev_clk = 1'b0;
    cyc(10);
    chk("mid_data_oe", ps2_data_oe, 1'b1);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    cyc(1);
    chk("mrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("mrst_busy", busy, 1'b0);
    cyc(2);
    dev_clk = 1'b1;
    reset = 1'b0;
    cyc(1);
    chk("mrst_ready", tx_ready, 1'b1);
    cyc(20);
    chk("mrst_no_pulses", (done_cnt - d0) + (nack_cnt - a0) + (to_cnt - t0), 0);

    // tx_valid during SHIFT must not disturb the frame
    d0 = done_cnt;
    start(CMD_SET_LEDS, inh, req);
    pulses(11, 1'b1, 1'b1, fr);
    wait_done(n);
    chk("inj_frame", fr, 10'h3ED);
    cyc(200);
    chk("inj_done_cnt", done_cnt - d0, 1);
    chk("inj_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
